// File: rtl/scpu_pkg.sv
// Shared definitions for the small CPU front end: fetch FSM states and opcode length decode.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package scpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_OP   = 3'd2,
    S_B1   = 3'd3,
    S_B2   = 3'd4,
    S_OUT  = 3'd5
  } fetch_state_t;

  // Opcode bits that encode the instruction byte length.
  localparam int OPC_LEN_MSB = 7;
  localparam int OPC_LEN_LSB = 6;

  // 00 -> 1 byte, 01 -> 2 bytes, 10 -> 3 bytes, 11 (reserved) -> 1 byte.
  function automatic logic [1:0] instr_len(input logic [7:0] opcode);
    logic [1:0] fld;
    fld = opcode[OPC_LEN_MSB:OPC_LEN_LSB];
    case (fld)
      2'b01:   instr_len = 2'd2;
      2'b10:   instr_len = 2'd3;
      default: instr_len = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetches 1-3 byte instructions from 8-bit program memory and presents them as one bundle.
// Latency: S_REQ entry to ins_valid is 2/3/4 cycles for 1/2/3-byte instructions.
// Backpressure: bundle and PC hold in S_OUT while ins_ready=0; no memory reads are issued.
module instr_fetch
  import scpu_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_r,
  input  logic [7:0]        mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [7:0]        ins_opcode,
  output logic [7:0]        ins_op1,
  output logic [7:0]        ins_op2,
  output logic [1:0]        ins_len,
  output logic [ADDR_W-1:0] ins_pc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [7:0]        opcode_q, opcode_d;
  logic [7:0]        op1_q, op1_d;
  logic [7:0]        op2_q, op2_d;
  logic [1:0]        len_q, len_d;
  logic [ADDR_W-1:0] ins_pc_q, ins_pc_d;
  logic [1:0]        rdata_len;

  // PC increment wraps naturally modulo 2**ADDR_W.
  assign pc_inc    = pc_q + PC_ONE;
  assign rdata_len = instr_len(mem_rdata);

  // Next-state, PC, bundle capture and memory request generation.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    len_d    = len_q;
    ins_pc_d = ins_pc_q;
    mem_r    = 1'b0;
    mem_addr = pc_q;

    if (redirect) begin
      // Redirect wins everywhere: drop partial bytes, issue no read this cycle.
      // A handshake in the same cycle still completes since ins_valid is state-based.
      pc_d    = redirect_addr;
      state_d = en ? S_REQ : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en) state_d = S_REQ;
        end
        S_REQ: begin
          mem_r   = 1'b1;
          state_d = S_OP;
        end
        S_OP: begin
          opcode_d = mem_rdata;
          op1_d    = 8'h00;
          op2_d    = 8'h00;
          len_d    = rdata_len;
          ins_pc_d = pc_q;
          pc_d     = pc_inc;
          if (rdata_len > 2'd1) begin
            mem_r    = 1'b1;
            mem_addr = pc_inc;
            state_d  = S_B1;
          end else begin
            state_d = S_OUT;
          end
        end
        S_B1: begin
          op1_d = mem_rdata;
          pc_d  = pc_inc;
          if (len_q == 2'd3) begin
            mem_r    = 1'b1;
            mem_addr = pc_inc;
            state_d  = S_B2;
          end else begin
            state_d = S_OUT;
          end
        end
        S_B2: begin
          op2_d   = mem_rdata;
          pc_d    = pc_inc;
          state_d = S_OUT;
        end
        S_OUT: begin
          if (ins_ready) state_d = en ? S_REQ : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, PC and bundle registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      opcode_q <= 8'h00;
      op1_q    <= 8'h00;
      op2_q    <= 8'h00;
      len_q    <= 2'd0;
      ins_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      len_q    <= len_d;
      ins_pc_q <= ins_pc_d;
    end
  end

  assign ins_valid  = (state_q == S_OUT);
  assign ins_opcode = opcode_q;
  assign ins_op1    = op1_q;
  assign ins_op2    = op2_q;
  assign ins_len    = len_q;
  assign ins_pc     = ins_pc_q;
  assign pc         = pc_q;

endmodule
